// File: rtl/idecode_pkg.sv
// Shared decode constants: opcode classes, micro-code count table, bubble value and
// field offsets of the 92-bit decode-to-CU bundle.
package idecode_pkg;

  localparam logic [5:0] OP_NOP     = 6'h00;
  localparam logic [5:0] OP_BR_BASE = 6'h10;

  localparam logic [7:0] UCADDR_BUBBLE = 8'hFF;

  // Bundle layout
  localparam int unsigned BUNDLE_W  = 92;
  localparam int unsigned F_INSTR   = 0;
  localparam int unsigned F_UCADDR  = 32;
  localparam int unsigned F_UCCNT   = 40;
  localparam int unsigned F_IMM     = 43;
  localparam int unsigned F_NT_ADDR = 75;
  localparam int unsigned F_BR_PC   = 83;
  localparam int unsigned F_TAKEN   = 91;

  // Bubble: NOP word, micro-code address 0xFF, everything else zero
  localparam logic [BUNDLE_W-1:0] BUNDLE_BUBBLE =
      (BUNDLE_W'(UCADDR_BUBBLE) << F_UCADDR) | BUNDLE_W'({OP_NOP, 26'd0});

  // Micro-op count per opcode[4:0]: (idx mod 7) + 1
  localparam logic [2:0] UCODE_CNT [32] = '{
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
    3'd1, 3'd2, 3'd3, 3'd4
  };

  localparam logic [1:0] BHT_INIT = 2'b01;

  // Branch class is opcodes 0x10-0x17
  function automatic logic is_branch(input logic [5:0] op);
    return op[5:3] == OP_BR_BASE[5:3];
  endfunction

endpackage

// File: rtl/idecode_bht.sv
// 2-bit saturating branch history table. Lookup is combinational from the current
// counters, so a same-cycle update to the same index is not visible until next cycle.
module idecode_bht import idecode_pkg::*; #(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic [1:0]       lookup_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned Entries = 1 << IDX_W;

  logic [1:0] ctr_q [Entries];

  assign lookup_ctr = ctr_q[lookup_idx];

  // Counter array: saturating increment on taken, decrement on not-taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr_q <= '{default: BHT_INIT};
    end else if (upd_en) begin
      if (upd_taken && ctr_q[upd_idx] != 2'b11) begin
        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
      end else if (!upd_taken && ctr_q[upd_idx] != 2'b00) begin
        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/idecode_cu_issue.sv
// Decode-side issue stage: 2-entry instruction queue, opcode decode into the CU bundle,
// branch prediction and fetch redirect. Define IDECODE_BHT_EN for BHT-based prediction;
// otherwise backward branches are predicted taken and the BHT update ports are ignored.
module idecode_cu_issue import idecode_pkg::*; #(
  parameter int unsigned BHT_IDX_W  = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_pipeline,
  input  logic                fetch_valid,
  input  logic [31:0]         fetch_instr,
  input  logic [7:0]          fetch_pc,
  output logic                fetch_ready,
  input  logic                cu_exec_ready,
  output logic [BUNDLE_W-1:0] idecode_cu_interface,
  output logic                redirect_valid,
  output logic [7:0]          redirect_addr,
  input  logic                bht_upd_en,
  input  logic [7:0]          bht_upd_pc,
  input  logic                bht_upd_taken
);

  localparam logic [1:0] QDepth = 2'(FIFO_DEPTH);

  // Queue is a 2-slot shift register; slot 0 is always the head
  logic [31:0]         q_instr_q [2];
  logic [31:0]         q_instr_d [2];
  logic [7:0]          q_pc_q    [2];
  logic [7:0]          q_pc_d    [2];
  logic [1:0]          count_q, count_d;
  logic                fetch_ready_q;
  logic [BUNDLE_W-1:0] out_q, out_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [7:0]          redirect_addr_q, redirect_addr_d;

  logic [31:0]         head_instr;
  logic [7:0]          head_pc;
  logic [5:0]          head_op;
  logic                pred_taken;
  logic [BUNDLE_W-1:0] dec;
  logic                push, issue, redirect, out_bubble;

  assign head_instr = q_instr_q[0];
  assign head_pc    = q_pc_q[0];
  assign head_op    = head_instr[31:26];

`ifdef IDECODE_BHT_EN
  logic [1:0] bht_ctr;

  idecode_bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .lookup_idx (head_pc[BHT_IDX_W-1:0]),
    .lookup_ctr (bht_ctr),
    .upd_en     (bht_upd_en),
    .upd_idx    (bht_upd_pc[BHT_IDX_W-1:0]),
    .upd_taken  (bht_upd_taken)
  );

  assign pred_taken = bht_ctr[1];
`else
  logic unused_bht;
  assign unused_bht = ^{bht_upd_en, bht_upd_pc, bht_upd_taken, 1'(BHT_IDX_W)};
  // Static rule: backward branch predicted taken
  assign pred_taken = head_instr[7:0] < head_pc;
`endif

  // Decode the queue head into a bundle; illegal opcodes become a bubble carrying the word
  always_comb begin
    dec = BUNDLE_BUBBLE;
    dec[F_INSTR +: 32] = head_instr;
    if (!head_op[5]) begin
      dec[F_UCADDR +: 8] = {head_op[4:0], 3'b000};
      dec[F_UCCNT +: 3]  = UCODE_CNT[head_op[4:0]];
      dec[F_IMM +: 32]   = {{16{head_instr[15]}}, head_instr[15:0]};
      if (is_branch(head_op)) begin
        dec[F_NT_ADDR +: 8] = head_pc + 8'd1;
        dec[F_BR_PC +: 8]   = head_pc;
        dec[F_TAKEN]        = pred_taken;
      end
    end
  end

  assign push       = fetch_valid & fetch_ready_q;
  assign out_bubble = out_q[F_UCADDR +: 8] == UCADDR_BUBBLE;
  assign issue      = (count_q != 2'd0) && (out_bubble || cu_exec_ready);
  assign redirect   = issue && dec[F_TAKEN];

  // Next-state: flush beats issue/redirect beats push
  always_comb begin
    q_instr_d        = q_instr_q;
    q_pc_d           = q_pc_q;
    count_d          = count_q;
    out_d            = out_q;
    redirect_valid_d = 1'b0;
    redirect_addr_d  = redirect_addr_q;
    if (flush_pipeline) begin
      count_d = 2'd0;
      out_d   = BUNDLE_BUBBLE;
    end else if (issue) begin
      out_d = dec;
      if (redirect) begin
        // Younger queued and same-cycle fetched words are on the wrong path
        count_d          = 2'd0;
        redirect_valid_d = 1'b1;
        redirect_addr_d  = head_instr[7:0];
      end else begin
        q_instr_d[0] = q_instr_q[1];
        q_pc_d[0]    = q_pc_q[1];
        count_d      = count_q - 2'd1;
        if (push) begin
          q_instr_d[count_q[1]] = fetch_instr;
          q_pc_d[count_q[1]]    = fetch_pc;
          count_d               = count_q;
        end
      end
    end else begin
      // No issue with cu_exec_ready set implies an empty queue
      if (cu_exec_ready) out_d = BUNDLE_BUBBLE;
      if (push) begin
        q_instr_d[count_q[0]] = fetch_instr;
        q_pc_d[count_q[0]]    = fetch_pc;
        count_d               = count_q + 2'd1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_instr_q        <= '{default: '0};
      q_pc_q           <= '{default: '0};
      count_q          <= 2'd0;
      fetch_ready_q    <= 1'b1;
      out_q            <= BUNDLE_BUBBLE;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= 8'd0;
    end else begin
      q_instr_q        <= q_instr_d;
      q_pc_q           <= q_pc_d;
      count_q          <= count_d;
      fetch_ready_q    <= count_d < QDepth;
      out_q            <= out_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
    end
  end

  assign fetch_ready          = fetch_ready_q;
  assign idecode_cu_interface = out_q;
  assign redirect_valid       = redirect_valid_q;
  assign redirect_addr        = redirect_addr_q;

endmodule

// File: tb/tb_idecode_cu_issue.sv
// Directed bench for idecode_cu_issue. Inputs change and outputs are sampled on the
// falling clock edge; expected bundles are composed from hand-computed field values.
module tb_idecode_cu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_pipeline;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [7:0]  fetch_pc;
  logic        fetch_ready;
  logic        cu_exec_ready;
  logic [91:0] idecode_cu_interface;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        bht_upd_en;
  logic [7:0]  bht_upd_pc;
  logic        bht_upd_taken;

  int checks   = 0;
  int failures = 0;

  localparam logic [91:0] BUBBLE = {52'd0, 8'hFF, 32'd0};

  idecode_cu_issue dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush_pipeline       (flush_pipeline),
    .fetch_valid          (fetch_valid),
    .fetch_instr          (fetch_instr),
    .fetch_pc             (fetch_pc),
    .fetch_ready          (fetch_ready),
    .cu_exec_ready        (cu_exec_ready),
    .idecode_cu_interface (idecode_cu_interface),
    .redirect_valid       (redirect_valid),
    .redirect_addr        (redirect_addr),
    .bht_upd_en           (bht_upd_en),
    .bht_upd_pc           (bht_upd_pc),
    .bht_upd_taken        (bht_upd_taken)
  );

  always #5 clk = ~clk;

  // Bundle composer: {taken, branch pc, not-taken addr, imm, cnt, ucode addr, instr}
  function automatic logic [91:0] mk(input logic tk, input logic [7:0] bpc,
                                     input logic [7:0] nt, input logic [31:0] imm,
                                     input logic [2:0] cnt, input logic [7:0] addr,
                                     input logic [31:0] ins);
    return {tk, bpc, nt, imm, cnt, addr, ins};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drain();
    fetch_valid = 1'b0;
    cu_exec_ready = 1'b1;
    repeat (3) tick();
    cu_exec_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [91:0] exp_b;
    exp_b = BUBBLE;
    repeat (2) tick();
    checks++;
    if (idecode_cu_interface !== exp_b) begin
      failures++;
      $display("FAIL reset_bundle: got %h want %h", idecode_cu_interface, exp_b);
    end
    checks++;
    if (fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready);
    end
    checks++;
    if (redirect_valid !== 1'b0 || redirect_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_redirect: got %b/%h want 0/00", redirect_valid, redirect_addr);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [91:0] exp_a;
    exp_a = mk(1'b0, 8'h00, 8'h00, 32'h0, 3'd2, 8'h08, 32'h04000000);
    fetch_valid = 1'b1; fetch_instr = 32'h04000000; fetch_pc = 8'h10;
    tick();
    fetch_valid = 1'b0;
    checks++;
    if (idecode_cu_interface !== BUBBLE) begin
      failures++;
      $display("FAIL basic_latency: got %h want %h", idecode_cu_interface, BUBBLE);
    end
    tick();
    checks++;
    if (idecode_cu_interface !== exp_a) begin
      failures++;
      $display("FAIL basic_issue: got %h want %h", idecode_cu_interface, exp_a);
    end
    repeat (3) tick();
    checks++;
    if (idecode_cu_interface !== exp_a) begin
      failures++;
      $display("FAIL basic_hold: got %h want %h", idecode_cu_interface, exp_a);
    end
    cu_exec_ready = 1'b1;
    tick();
    cu_exec_ready = 1'b0;
    checks++;
    if (idecode_cu_interface !== BUBBLE) begin
      failures++;
      $display("FAIL basic_drain: got %h want %h", idecode_cu_interface, BUBBLE);
    end
  endtask

  task automatic test_fill_order();
    logic [91:0] ea, eb, ec, ed;
    ea = mk(1'b0, 8'h00, 8'h00, 32'h00000001, 3'd2, 8'h08, 32'h04000001);
    eb = mk(1'b0, 8'h00, 8'h00, 32'h00000002, 3'd3, 8'h10, 32'h08000002);
    ec = mk(1'b0, 8'h00, 8'h00, 32'h00000003, 3'd4, 8'h18, 32'h0C000003);
    ed = mk(1'b0, 8'h00, 8'h00, 32'hFFFF8005, 3'd5, 8'h20, 32'h10008005);
    fetch_valid = 1'b1; fetch_instr = 32'h04000001; fetch_pc = 8'h20;
    tick();
    fetch_instr = 32'h08000002; fetch_pc = 8'h21;
    tick();
    fetch_instr = 32'h0C000003; fetch_pc = 8'h22;
    tick();
    checks++;
    if (fetch_ready !== 1'b0 || idecode_cu_interface !== ea) begin
      failures++;
      $display("FAIL fill_full: got ready=%b %h want ready=0 %h", fetch_ready,
               idecode_cu_interface, ea);
    end
    fetch_instr = 32'h10008005; fetch_pc = 8'h23;
    tick();
    checks++;
    if (fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_blocked: got %b want 0", fetch_ready);
    end
    cu_exec_ready = 1'b1;
    tick();
    checks++;
    if (idecode_cu_interface !== eb || fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_pop_b: got ready=%b %h want ready=1 %h", fetch_ready,
               idecode_cu_interface, eb);
    end
    cu_exec_ready = 1'b0;
    tick();
    checks++;
    if (fetch_ready !== 1'b0 || idecode_cu_interface !== eb) begin
      failures++;
      $display("FAIL fill_third_in: got ready=%b %h want ready=0 %h", fetch_ready,
               idecode_cu_interface, eb);
    end
    fetch_valid = 1'b0;
    cu_exec_ready = 1'b1;
    tick();
    checks++;
    if (idecode_cu_interface !== ec) begin
      failures++;
      $display("FAIL fill_order_c: got %h want %h", idecode_cu_interface, ec);
    end
    tick();
    checks++;
    if (idecode_cu_interface !== ed) begin
      failures++;
      $display("FAIL fill_order_d: got %h want %h", idecode_cu_interface, ed);
    end
    tick();
    cu_exec_ready = 1'b0;
    checks++;
    if (idecode_cu_interface !== BUBBLE) begin
      failures++;
      $display("FAIL fill_empty: got %h want %h", idecode_cu_interface, BUBBLE);
    end
  endtask

  // Issue a taken branch with a younger fetch in the same cycle; younger must vanish
  task automatic taken_branch(input logic [31:0] ins, input logic [7:0] pc,
                              input logic [91:0] exp_br, input logic [7:0] exp_tgt);
    fetch_valid = 1'b1; fetch_instr = ins; fetch_pc = pc;
    tick();
    fetch_instr = 32'h04000000; fetch_pc = pc + 8'd1;
    tick();
    fetch_valid = 1'b0;
    checks++;
    if (idecode_cu_interface !== exp_br) begin
      failures++;
      $display("FAIL taken_bundle: got %h want %h", idecode_cu_interface, exp_br);
    end
    checks++;
    if (redirect_valid !== 1'b1 || redirect_addr !== exp_tgt) begin
      failures++;
      $display("FAIL taken_redirect: got %b/%h want 1/%h", redirect_valid, redirect_addr,
               exp_tgt);
    end
    cu_exec_ready = 1'b1;
    tick();
    cu_exec_ready = 1'b0;
    checks++;
    if (redirect_valid !== 1'b0 || idecode_cu_interface !== BUBBLE) begin
      failures++;
      $display("FAIL taken_younger_dropped: got rv=%b %h want rv=0 %h", redirect_valid,
               idecode_cu_interface, BUBBLE);
    end
  endtask

`ifdef IDECODE_BHT_EN
  task automatic test_bht();
    bht_upd_en = 1'b1; bht_upd_pc = 8'h05; bht_upd_taken = 1'b1;
    repeat (2) tick();
    bht_upd_en = 1'b0;
    taken_branch(32'h40000020, 8'h05,
                 mk(1'b1, 8'h05, 8'h06, 32'h20, 3'd3, 8'h80, 32'h40000020), 8'h20);
  endtask
`else
  task automatic test_static();
    logic [91:0] exp_nt;
    taken_branch(32'h40000010, 8'h30,
                 mk(1'b1, 8'h30, 8'h31, 32'h10, 3'd3, 8'h80, 32'h40000010), 8'h10);
    exp_nt = mk(1'b0, 8'h30, 8'h31, 32'h40, 3'd3, 8'h80, 32'h40000040);
    fetch_valid = 1'b1; fetch_instr = 32'h40000040; fetch_pc = 8'h30;
    tick();
    fetch_valid = 1'b0;
    tick();
    checks++;
    if (idecode_cu_interface !== exp_nt || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL static_forward_nt: got rv=%b %h want rv=0 %h", redirect_valid,
               idecode_cu_interface, exp_nt);
    end
  endtask
`endif

  task automatic test_pc_wrap();
    logic        tk;
    logic [91:0] exp_w;
`ifdef IDECODE_BHT_EN
    tk = 1'b0;  // index 0xF still weakly not-taken
`else
    tk = 1'b1;  // target 0x80 below pc 0xFF
`endif
    exp_w = mk(tk, 8'hFF, 8'h00, 32'h80, 3'd3, 8'h80, 32'h40000080);
    drain();
    fetch_valid = 1'b1; fetch_instr = 32'h40000080; fetch_pc = 8'hFF;
    tick();
    fetch_valid = 1'b0;
    tick();
    checks++;
    if (idecode_cu_interface !== exp_w) begin
      failures++;
      $display("FAIL pc_wrap_bundle: got %h want %h", idecode_cu_interface, exp_w);
    end
    checks++;
    if (redirect_valid !== tk) begin
      failures++;
      $display("FAIL pc_wrap_redirect: got %b want %b", redirect_valid, tk);
    end
    drain();
  endtask

  task automatic test_illegal();
    logic [91:0] exp_i;
    exp_i = {52'd0, 8'hFF, 32'hFC001234};
    fetch_valid = 1'b1; fetch_instr = 32'hFC001234; fetch_pc = 8'h50;
    tick();
    fetch_valid = 1'b0;
    tick();
    checks++;
    if (idecode_cu_interface !== exp_i) begin
      failures++;
      $display("FAIL illegal_bubble: got %h want %h", idecode_cu_interface, exp_i);
    end
    drain();
  endtask

  task automatic test_flush();
    fetch_valid = 1'b1; fetch_instr = 32'h04000000; fetch_pc = 8'h60;
    tick();
    fetch_instr = 32'h08000000; fetch_pc = 8'h61;
    tick();
    fetch_instr = 32'h0C000000; fetch_pc = 8'h62;
    tick();
    checks++;
    if (fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_prefull: got %b want 0", fetch_ready);
    end
    flush_pipeline = 1'b1;
    fetch_instr = 32'h10000000; fetch_pc = 8'h63;
    tick();
    flush_pipeline = 1'b0;
    fetch_valid = 1'b0;
    checks++;
    if (idecode_cu_interface !== BUBBLE || fetch_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_state: got ready=%b rv=%b %h want ready=1 rv=0 %h", fetch_ready,
               redirect_valid, idecode_cu_interface, BUBBLE);
    end
    tick();
    checks++;
    if (idecode_cu_interface !== BUBBLE) begin
      failures++;
      $display("FAIL flush_nothing_issues: got %h want %h", idecode_cu_interface, BUBBLE);
    end
  endtask

  task automatic test_reset_mid();
    fetch_valid = 1'b1; fetch_instr = 32'h04000000; fetch_pc = 8'h40;
    tick();
    fetch_instr = 32'h08000000; fetch_pc = 8'h41;
    tick();
    fetch_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (idecode_cu_interface !== BUBBLE || fetch_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_async: got ready=%b %h want ready=1 %h", fetch_ready,
               idecode_cu_interface, BUBBLE);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (idecode_cu_interface !== BUBBLE) begin
      failures++;
      $display("FAIL reset_mid_queue: got %h want %h", idecode_cu_interface, BUBBLE);
    end
  endtask

  initial begin
    rst = 1'b0;
    flush_pipeline = 1'b0;
    fetch_valid = 1'b0;
    fetch_instr = 32'd0;
    fetch_pc = 8'd0;
    cu_exec_ready = 1'b0;
    bht_upd_en = 1'b0;
    bht_upd_pc = 8'd0;
    bht_upd_taken = 1'b0;
    test_reset();
    test_basic();
    test_fill_order();
`ifdef IDECODE_BHT_EN
    test_bht();
`else
    test_static();
`endif
    test_pc_wrap();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
